// File: rtl/fp_helper_stage.sv
// One-cycle registered stage for the FP adder: operand classification,
// leading-one detection and final rounding, all evaluated in parallel.
module fp_helper_stage #(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned ROUND_TO_NEAREST = 1,
    parameter int unsigned ROUNDING_BITS    = 3,
    parameter int unsigned LOD_WIDTH        = MANTISSA_WIDTH + 2 + ROUNDING_BITS,
    localparam int unsigned LOD_POS_W       = (LOD_WIDTH > 1) ? $clog2(LOD_WIDTH) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   operand,
    input  logic [LOD_WIDTH-1:0]                     lod_value,
    input  logic [EXPONENT_WIDTH-1:0]                rnd_exponent,
    input  logic [MANTISSA_WIDTH-1:0]                rnd_mantissa,
    input  logic [ROUNDING_BITS-1:0]                 rnd_bits,
    output logic                                     out_valid,
    output logic                                     is_infinite,
    output logic                                     is_zero,
    output logic                                     is_signaling_nan,
    output logic                                     is_quiet_nan,
    output logic                                     is_subnormal,
    output logic [LOD_POS_W-1:0]                     lod_position,
    output logic                                     lod_found,
    output logic [EXPONENT_WIDTH-1:0]                rounded_exponent,
    output logic [MANTISSA_WIDTH-1:0]                rounded_mantissa,
    output logic                                     round_overflow
);

    localparam int unsigned E = EXPONENT_WIDTH;
    localparam int unsigned M = MANTISSA_WIDTH;
    localparam int unsigned R = ROUNDING_BITS;
    localparam bit IS_E4M3    = (E == 4) && (M == 3);

    logic [E-1:0] op_exp;
    logic [M-1:0] op_man;
    logic         unused_sign;

    assign op_exp      = operand[E+M-1:M];
    assign op_man      = operand[M-1:0];
    assign unused_sign = operand[E+M];

    logic inf_c, zero_c, snan_c, qnan_c, sub_c;

    // Classification; E4M3 has no infinity and a single NaN encoding
    always_comb begin
        inf_c  = 1'b0;
        zero_c = 1'b0;
        snan_c = 1'b0;
        qnan_c = 1'b0;
        sub_c  = 1'b0;
        if (op_exp == '0) begin
            zero_c = (op_man == '0);
            sub_c  = (op_man != '0);
        end else if (&op_exp) begin
            if (IS_E4M3) begin
                qnan_c = &op_man;
            end else begin
                inf_c  = (op_man == '0);
                qnan_c = op_man[M-1];
                snan_c = !op_man[M-1] && (op_man != '0);
            end
        end
    end

    logic [LOD_POS_W-1:0] lod_pos_c;
    logic                 lod_found_c;

    // Leading-one scan: the last hit from LSB upward is the highest set bit
    always_comb begin
        lod_pos_c   = '0;
        lod_found_c = 1'b0;
        for (int i = 0; i < int'(LOD_WIDTH); i++) begin
            if (lod_value[i]) begin
                lod_pos_c   = LOD_POS_W'(i);
                lod_found_c = 1'b1;
            end
        end
    end

    logic         guard, sticky, round_up;
    logic [M:0]   man_sum;
    logic [E:0]   exp_sum;
    logic         ovf_c;
    logic [E-1:0] rnd_exp_c;
    logic [M-1:0] rnd_man_c;

    // Round-to-nearest-even; a mantissa carry bumps the exponent, saturating to infinity
    always_comb begin
        guard     = rnd_bits[R-1];
        sticky    = |rnd_bits[R-2:0];
        round_up  = (ROUND_TO_NEAREST != 0) && guard && (sticky || rnd_mantissa[0]);
        man_sum   = {1'b0, rnd_mantissa} + (M+1)'(round_up);
        exp_sum   = {1'b0, rnd_exponent} + (E+1)'(man_sum[M]);
        ovf_c     = exp_sum[E] || (&exp_sum[E-1:0]);
        rnd_exp_c = ovf_c ? '1 : exp_sum[E-1:0];
        rnd_man_c = ovf_c ? '0 : man_sum[M-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            is_infinite      <= 1'b0;
            is_zero          <= 1'b0;
            is_signaling_nan <= 1'b0;
            is_quiet_nan     <= 1'b0;
            is_subnormal     <= 1'b0;
            lod_position     <= '0;
            lod_found        <= 1'b0;
            rounded_exponent <= '0;
            rounded_mantissa <= '0;
            round_overflow   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                is_infinite      <= inf_c;
                is_zero          <= zero_c;
                is_signaling_nan <= snan_c;
                is_quiet_nan     <= qnan_c;
                is_subnormal     <= sub_c;
                lod_position     <= lod_pos_c;
                lod_found        <= lod_found_c;
                rounded_exponent <= rnd_exp_c;
                rounded_mantissa <= rnd_man_c;
                round_overflow   <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_helper_stage.sv
// Directed bench for fp_helper_stage: float32 nearest-even, float32 truncating
// and E4M3 instances driven from hand-computed vector tables.
module tb_fp_helper_stage;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    always #5 clk = ~clk;

    // float32 stimulus shared by the nearest-even and truncating instances
    logic [31:0] operand;
    logic [27:0] lod_value;
    logic [7:0]  rnd_exponent;
    logic [22:0] rnd_mantissa;
    logic [2:0]  rnd_bits;

    logic        out_valid, is_infinite, is_zero, is_signaling_nan, is_quiet_nan, is_subnormal;
    logic [4:0]  lod_position;
    logic        lod_found;
    logic [7:0]  rounded_exponent;
    logic [22:0] rounded_mantissa;
    logic        round_overflow;

    logic        t_out_valid, t_inf, t_zero, t_snan, t_qnan, t_sub;
    logic [4:0]  t_lod_position;
    logic        t_lod_found;
    logic [7:0]  t_rounded_exponent;
    logic [22:0] t_rounded_mantissa;
    logic        t_round_overflow;

    logic [7:0]  e_operand;
    logic [7:0]  e_lod_value;
    logic [3:0]  e_rnd_exponent;
    logic [2:0]  e_rnd_mantissa;
    logic [2:0]  e_rnd_bits;
    logic        e_out_valid, e_inf, e_zero, e_snan, e_qnan, e_sub;
    logic [2:0]  e_lod_position;
    logic        e_lod_found;
    logic [3:0]  e_rounded_exponent;
    logic [2:0]  e_rounded_mantissa;
    logic        e_round_overflow;

    fp_helper_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .operand(operand), .lod_value(lod_value),
        .rnd_exponent(rnd_exponent), .rnd_mantissa(rnd_mantissa), .rnd_bits(rnd_bits),
        .out_valid(out_valid), .is_infinite(is_infinite), .is_zero(is_zero),
        .is_signaling_nan(is_signaling_nan), .is_quiet_nan(is_quiet_nan),
        .is_subnormal(is_subnormal), .lod_position(lod_position), .lod_found(lod_found),
        .rounded_exponent(rounded_exponent), .rounded_mantissa(rounded_mantissa),
        .round_overflow(round_overflow)
    );

    fp_helper_stage #(.ROUND_TO_NEAREST(0)) dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .operand(operand), .lod_value(lod_value),
        .rnd_exponent(rnd_exponent), .rnd_mantissa(rnd_mantissa), .rnd_bits(rnd_bits),
        .out_valid(t_out_valid), .is_infinite(t_inf), .is_zero(t_zero),
        .is_signaling_nan(t_snan), .is_quiet_nan(t_qnan),
        .is_subnormal(t_sub), .lod_position(t_lod_position), .lod_found(t_lod_found),
        .rounded_exponent(t_rounded_exponent), .rounded_mantissa(t_rounded_mantissa),
        .round_overflow(t_round_overflow)
    );

    fp_helper_stage #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3)) dut_e4m3 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .operand(e_operand), .lod_value(e_lod_value),
        .rnd_exponent(e_rnd_exponent), .rnd_mantissa(e_rnd_mantissa), .rnd_bits(e_rnd_bits),
        .out_valid(e_out_valid), .is_infinite(e_inf), .is_zero(e_zero),
        .is_signaling_nan(e_snan), .is_quiet_nan(e_qnan),
        .is_subnormal(e_sub), .lod_position(e_lod_position), .lod_found(e_lod_found),
        .rounded_exponent(e_rounded_exponent), .rounded_mantissa(e_rounded_mantissa),
        .round_overflow(e_round_overflow)
    );

    // flags packed as {inf, zero, snan, qnan, sub}
    typedef struct {
        logic [31:0] op;
        logic [27:0] lod;
        logic [7:0]  rexp;
        logic [22:0] rman;
        logic [2:0]  rbits;
        logic [4:0]  flags;
        logic [4:0]  pos;
        logic        found;
        logic [7:0]  oexp;
        logic [22:0] oman;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [7:0] op;
        logic [4:0] flags;
    } evec_t;

    vec_t  vecs[8];
    evec_t evecs[5];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        operand      = v.op;
        lod_value    = v.lod;
        rnd_exponent = v.rexp;
        rnd_mantissa = v.rman;
        rnd_bits     = v.rbits;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " flags"}, 64'({is_infinite, is_zero, is_signaling_nan, is_quiet_nan, is_subnormal}), 64'd0);
        check({tag, " lod"}, 64'({lod_position, lod_found}), 64'd0);
        check({tag, " round"}, 64'({rounded_exponent, rounded_mantissa, round_overflow}), 64'd0);
        check({tag, " trunc"}, 64'({t_out_valid, t_rounded_exponent, t_rounded_mantissa}), 64'd0);
        check({tag, " e4m3"}, 64'({e_out_valid, e_inf, e_zero, e_snan, e_qnan, e_sub}), 64'd0);
    endtask

    initial begin
        //          op            lod           rexp   rman         rbits   flags     pos  f  oexp   oman         ovf
        vecs[0] = '{32'h7F800000, 28'h0000001, 8'h7F, 23'h000000, 3'b100, 5'b10000, 5'd0,  1, 8'h7F, 23'h000000, 0};
        vecs[1] = '{32'h7FC00000, 28'h8000000, 8'h7F, 23'h000000, 3'b101, 5'b00010, 5'd27, 1, 8'h7F, 23'h000001, 0};
        vecs[2] = '{32'h7F800001, 28'h0000000, 8'h7F, 23'h7FFFFF, 3'b100, 5'b00100, 5'd0,  0, 8'h80, 23'h000000, 0};
        vecs[3] = '{32'h80000000, 28'h00F0000, 8'hFE, 23'h7FFFFF, 3'b110, 5'b01000, 5'd19, 1, 8'hFF, 23'h000000, 1};
        vecs[4] = '{32'h00000001, 28'h0000003, 8'h10, 23'h123456, 3'b011, 5'b00001, 5'd1,  1, 8'h10, 23'h123456, 0};
        vecs[5] = '{32'h3F800000, 28'hFFFFFFF, 8'h10, 23'h000001, 3'b100, 5'b00000, 5'd27, 1, 8'h10, 23'h000002, 0};
        vecs[6] = '{32'hFF800000, 28'h0000100, 8'h00, 23'h000000, 3'b111, 5'b10000, 5'd8,  1, 8'h00, 23'h000001, 0};
        vecs[7] = '{32'h7F7FFFFF, 28'h4000000, 8'h01, 23'h7FFFFF, 3'b011, 5'b00000, 5'd26, 1, 8'h01, 23'h7FFFFF, 0};

        evecs[0] = '{8'h7F, 5'b00010};
        evecs[1] = '{8'h78, 5'b00000};
        evecs[2] = '{8'h00, 5'b01000};
        evecs[3] = '{8'hF8, 5'b00000};
        evecs[4] = '{8'h01, 5'b00001};

        rst = 1'b1;
        in_valid = 1'b0;
        drive(vecs[0]);
        e_operand      = 8'h00;
        e_lod_value    = 8'h00;
        e_rnd_exponent = 4'h0;
        e_rnd_mantissa = 3'h0;
        e_rnd_bits     = 3'h0;
        step();
        step();
        check_all_zero("reset");

        // Main table: one vector per cycle, checked one edge later
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d flags", i),
                  64'({is_infinite, is_zero, is_signaling_nan, is_quiet_nan, is_subnormal}),
                  64'(vecs[i].flags));
            check($sformatf("v%0d lod_position", i), 64'(lod_position), 64'(vecs[i].pos));
            check($sformatf("v%0d lod_found", i), 64'(lod_found), 64'(vecs[i].found));
            check($sformatf("v%0d rounded_exponent", i), 64'(rounded_exponent), 64'(vecs[i].oexp));
            check($sformatf("v%0d rounded_mantissa", i), 64'(rounded_mantissa), 64'(vecs[i].oman));
            check($sformatf("v%0d round_overflow", i), 64'(round_overflow), 64'(vecs[i].ovf));
            // truncation passes the unrounded value straight through
            check($sformatf("v%0d trunc", i),
                  64'({t_rounded_exponent, t_rounded_mantissa, t_round_overflow}),
                  64'({vecs[i].rexp, vecs[i].rman, 1'b0}));
            @(negedge clk);
        end

        // E4M3 classification
        for (int i = 0; i < 5; i++) begin
            e_operand = evecs[i].op;
            step();
            check($sformatf("e4m3 op %0h flags", evecs[i].op),
                  64'({e_inf, e_zero, e_snan, e_qnan, e_sub}), 64'(evecs[i].flags));
            @(negedge clk);
        end

        // Single valid pulse, then hold with changed inputs
        in_valid = 1'b0;
        step();
        check("idle out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b1;
        drive(vecs[3]);
        step();
        check("pulse out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        drive(vecs[0]);
        step();
        check("hold out_valid", 64'(out_valid), 64'd0);
        check("hold flags", 64'({is_infinite, is_zero, is_signaling_nan, is_quiet_nan, is_subnormal}), 64'h08);
        check("hold lod", 64'({lod_position, lod_found}), 64'({5'd19, 1'b1}));
        check("hold round", 64'({rounded_exponent, rounded_mantissa, round_overflow}),
              64'({8'hFF, 23'h000000, 1'b1}));
        check("hold trunc", 64'({t_rounded_exponent, t_rounded_mantissa, t_round_overflow}),
              64'({8'hFE, 23'h7FFFFF, 1'b0}));
        step();
        check("hold2 out_valid", 64'(out_valid), 64'd0);
        check("hold2 exponent", 64'(rounded_exponent), 64'hFF);

        // Reset wins over a simultaneous valid input
        @(negedge clk);
        in_valid = 1'b1;
        drive(vecs[1]);
        e_operand = 8'h7F;
        rst = 1'b1;
        step();
        check_all_zero("rst_with_valid");

        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
